// File: rtl/alu_operand_loader_pkg.sv
// Shared types and constants for the ALU operand loader: FSM state encoding,
// key indices and default data widths.
package alu_loader_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    COMMIT  = 3'd3,
    HOLD    = 3'd4
  } loader_state_t;

  localparam int KEY_ENTER  = 0;
  localparam int KEY_CANCEL = 1;

  localparam int DEF_SW_W   = 16;
  localparam int DEF_DATA_W = 32;
  localparam int SEXT_W     = DEF_DATA_W - DEF_SW_W;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Board-side bundle of the operand loader: raw switches and keys in,
// registered ALU operands, opcode, commit pulse and state out.
interface alu_operand_loader_if #(
  parameter int SW_W   = 16,
  parameter int DATA_W = 32
);

  logic [SW_W-1:0]   sw_data;
  logic              sw_sext;
  logic [3:0]        key_n;
  logic [DATA_W-1:0] port_a;
  logic [DATA_W-1:0] port_b;
  logic [3:0]        aluop;
  logic              op_valid;
  logic [2:0]        state_o;

  modport master (
    output sw_data, sw_sext, key_n,
    input  port_a, port_b, aluop, op_valid, state_o
  );

  modport slave (
    input  sw_data, sw_sext, key_n,
    output port_a, port_b, aluop, op_valid, state_o
  );

endinterface

// File: rtl/alu_operand_loader_key_debounce.sv
// Synchronises one active-low push-button, debounces it and emits a one-cycle
// press pulse on each accepted released-to-pressed change.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic nRST,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_levelQ;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Any sample agreeing with the accepted level restarts the stability count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_levelQ <= 1'b1;
      r_press  <= 1'b0;
    end else begin
      r_levelQ <= r_level;
      r_press  <= r_levelQ & ~r_level;
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/alu_operand_loader.sv
// Operand load sequencer: captures A, B and the opcode from the switches on
// debounced enter presses and presents them as stable registered ALU inputs.
module alu_operand_loader
  import alu_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_W            = DEF_SW_W,
  parameter int DATA_W          = DEF_DATA_W
) (
  input  logic                 CLK,
  input  logic                 nRST,
  alu_operand_loader_if.slave  bus
);

  logic [SW_W:0]     r_swSync1;
  logic [SW_W:0]     r_swSync2;
  loader_state_t     r_state;
  loader_state_t     w_stateNext;
  logic [DATA_W-1:0] r_portA;
  logic [DATA_W-1:0] r_portB;
  logic [DATA_W-1:0] w_portANext;
  logic [DATA_W-1:0] w_portBNext;
  logic [DATA_W-1:0] w_ext;
  logic [3:0]        r_aluop;
  logic [3:0]        w_aluopNext;
  logic              r_opValid;
  logic              w_enterPress;
  logic              w_cancelPress;
  logic              w_enterLevel;
  logic              w_cancelLevel;
  logic              w_unused;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .CLK   (CLK),
    .nRST  (nRST),
    .key_n (bus.key_n[KEY_ENTER]),
    .level (w_enterLevel),
    .press (w_enterPress)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .CLK   (CLK),
    .nRST  (nRST),
    .key_n (bus.key_n[KEY_CANCEL]),
    .level (w_cancelLevel),
    .press (w_cancelPress)
  );

  assign w_unused = &{1'b0, bus.key_n[3:2], w_enterLevel, w_cancelLevel};

  // The sign-extend select travels with the data so both are captured coherently.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_swSync1 <= '0;
      r_swSync2 <= '0;
    end else begin
      r_swSync1 <= {bus.sw_sext, bus.sw_data};
      r_swSync2 <= r_swSync1;
    end
  end

  assign w_ext = r_swSync2[SW_W]
               ? {{(DATA_W-SW_W){r_swSync2[SW_W-1]}}, r_swSync2[SW_W-1:0]}
               : {{(DATA_W-SW_W){1'b0}}, r_swSync2[SW_W-1:0]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= WAIT_A;
      r_portA   <= '0;
      r_portB   <= '0;
      r_aluop   <= '0;
      r_opValid <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_portA   <= w_portANext;
      r_portB   <= w_portBNext;
      r_aluop   <= w_aluopNext;
      r_opValid <= (w_stateNext == COMMIT);
    end
  end

  // Cancel overrides everything, including an enter press landing on the same cycle.
  always_comb begin
    w_stateNext = r_state;
    w_portANext = r_portA;
    w_portBNext = r_portB;
    w_aluopNext = r_aluop;
    if (w_cancelPress) begin
      w_stateNext = WAIT_A;
      w_portANext = '0;
      w_portBNext = '0;
      w_aluopNext = '0;
    end else begin
      case (r_state)
        WAIT_A: begin
          if (w_enterPress) begin
            w_portANext = w_ext;
            w_stateNext = WAIT_B;
          end
        end
        WAIT_B: begin
          if (w_enterPress) begin
            w_portBNext = w_ext;
            w_stateNext = WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (w_enterPress) begin
            w_aluopNext = r_swSync2[3:0];
            w_stateNext = COMMIT;
          end
        end
        COMMIT: w_stateNext = HOLD;
        HOLD: begin
          if (w_enterPress) begin
            w_stateNext = WAIT_A;
          end
        end
        default: w_stateNext = WAIT_A;
      endcase
    end
  end

  assign bus.port_a   = r_portA;
  assign bus.port_b   = r_portB;
  assign bus.aluop    = r_aluop;
  assign bus.op_valid = r_opValid;
  assign bus.state_o  = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with a short debounce interval,
// scenario tasks plus randomized key/switch traffic against a behavioural model.
module tb_alu_operand_loader;
  import alu_loader_pkg::*;

  localparam int D = 4;

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  alu_operand_loader_if #(.SW_W(16), .DATA_W(32)) bus ();

  alu_operand_loader #(.DEBOUNCE_CYCLES(D), .SW_W(16), .DATA_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: a key press is accepted once D consecutive samples
  // disagree with the accepted level; its effect lands 4 edges after the
  // D-th sample. Switches reach the capture logic two samples late.
  logic [2:0]  mState;
  logic [31:0] mA;
  logic [31:0] mB;
  logic [3:0]  mOp;
  logic        mValid;
  logic [1:0]  mLvl;
  int          mRun [2];
  int          cyc;
  int          dueEnter [$];
  int          dueCancel [$];
  logic [16:0] mSwD1;
  logic [16:0] mSwD2;
  logic        fireE;
  logic        fireC;

  function automatic logic [31:0] extend(input logic [16:0] s);
    return s[16] ? {{SEXT_W{s[15]}}, s[15:0]} : {{SEXT_W{1'b0}}, s[15:0]};
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cyc = 0;
      mLvl = 2'b11;
      mRun[0] = 0;
      mRun[1] = 0;
      dueEnter.delete();
      dueCancel.delete();
      mSwD1 = '0;
      mSwD2 = '0;
      mState = 3'd0;
      mA = '0;
      mB = '0;
      mOp = '0;
      mValid = 1'b0;
    end else begin
      cyc++;
      fireE = (dueEnter.size() > 0) && (dueEnter[0] == cyc);
      if (fireE) void'(dueEnter.pop_front());
      fireC = (dueCancel.size() > 0) && (dueCancel[0] == cyc);
      if (fireC) void'(dueCancel.pop_front());
      if (fireC) begin
        mState = 3'd0; mA = '0; mB = '0; mOp = '0;
      end else begin
        case (mState)
          3'd0: if (fireE) begin mA = extend(mSwD2); mState = 3'd1; end
          3'd1: if (fireE) begin mB = extend(mSwD2); mState = 3'd2; end
          3'd2: if (fireE) begin mOp = mSwD2[3:0]; mState = 3'd3; end
          3'd3: mState = 3'd4;
          default: if (fireE) mState = 3'd0;
        endcase
      end
      mValid = (mState == 3'd3);
      mSwD2 = mSwD1;
      mSwD1 = {bus.sw_sext, bus.sw_data};
      for (int k = 0; k < 2; k++) begin
        if (bus.key_n[k] != mLvl[k]) mRun[k]++;
        else mRun[k] = 0;
        if (mRun[k] == D) begin
          mLvl[k] = bus.key_n[k];
          mRun[k] = 0;
          if (!mLvl[k]) begin
            if (k == KEY_ENTER) dueEnter.push_back(cyc + 4);
            else dueCancel.push_back(cyc + 4);
          end
        end
      end
    end
  end

  wire [71:0] dutVec   = {bus.port_a, bus.port_b, bus.aluop, bus.op_valid, bus.state_o};
  wire [71:0] modelVec = {mA, mB, mOp, mValid, mState};

  task automatic holdKeys(input logic [3:0] keys, input int n);
    bus.key_n = keys;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    bus.key_n = 4'hF;
    bus.sw_data = '0;
    bus.sw_sext = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (dutVec !== 72'd0) begin
      errors++; $display("[TB] FAIL reset_outputs actual %h expected %h", dutVec, 72'd0);
    end
    nRST = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.state_o !== 3'd0 || bus.op_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_idle state %0d valid %b expected 0 0", bus.state_o, bus.op_valid);
      end
    end
  endtask

  task automatic test_full_sequence;
    int pulses;
    bus.sw_data = 16'h8001; bus.sw_sext = 1'b1;
    holdKeys(4'hF, 3); holdKeys(4'b1110, 8); holdKeys(4'hF, 10);
    checks++;
    if (bus.port_a !== 32'hFFFF8001 || bus.state_o !== 3'd1) begin
      errors++; $display("[TB] FAIL seq_load_a port_a %h state %0d expected FFFF8001 1", bus.port_a, bus.state_o);
    end
    bus.sw_data = 16'h8003; bus.sw_sext = 1'b0;
    holdKeys(4'hF, 3); holdKeys(4'b1110, 8); holdKeys(4'hF, 10);
    checks++;
    if (bus.port_b !== 32'h00008003 || bus.state_o !== 3'd2) begin
      errors++; $display("[TB] FAIL seq_load_b port_b %h state %0d expected 00008003 2", bus.port_b, bus.state_o);
    end
    bus.sw_data = 16'h0002;
    holdKeys(4'hF, 3);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      bus.key_n = (i < 8) ? 4'b1110 : 4'hF;
      @(negedge CLK);
      if (bus.op_valid === 1'b1) begin
        pulses++;
        checks++;
        if (bus.state_o !== 3'd3) begin
          errors++; $display("[TB] FAIL seq_valid_state actual %0d expected 3", bus.state_o);
        end
      end
    end
    checks++;
    if (pulses !== 1 || bus.aluop !== 4'd2 || bus.state_o !== 3'd4) begin
      errors++; $display("[TB] FAIL seq_commit pulses %0d aluop %0d state %0d expected 1 2 4", pulses, bus.aluop, bus.state_o);
    end
    checks++;
    if (dutVec !== modelVec) begin
      errors++; $display("[TB] FAIL seq_model actual %h expected %h", dutVec, modelVec);
    end
  endtask

  task automatic test_hold;
    logic [15:0] sw;
    logic [2:0]  prevState;
    logic [31:0] prevA;
    int trans;
    int caps;
    holdKeys(4'b1110, 8); holdKeys(4'hF, 10);
    checks++;
    if (bus.state_o !== 3'd0 || bus.port_a !== 32'hFFFF8001) begin
      errors++; $display("[TB] FAIL hold_return state %0d port_a %h expected 0 FFFF8001", bus.state_o, bus.port_a);
    end
    sw = 16'($urandom);
    bus.sw_data = sw; bus.sw_sext = 1'b0;
    holdKeys(4'hF, 3);
    prevState = bus.state_o; prevA = bus.port_a; trans = 0; caps = 0;
    for (int i = 0; i < 212; i++) begin
      bus.key_n = (i < 200) ? 4'b1110 : 4'hF;
      @(negedge CLK);
      if (bus.state_o !== prevState) trans++;
      if (bus.port_a !== prevA) caps++;
      prevState = bus.state_o; prevA = bus.port_a;
    end
    checks++;
    if (trans !== 1 || caps !== 1 || bus.state_o !== 3'd1 || bus.port_a !== {16'h0, sw}) begin
      errors++; $display("[TB] FAIL hold_single trans %0d caps %0d state %0d port_a %h expected 1 1 1 %h",
                         trans, caps, bus.state_o, bus.port_a, {16'h0, sw});
    end
  endtask

  task automatic test_bounce;
    logic [31:0] prevB;
    logic [15:0] sw;
    int changes;
    int firstChange;
    prevB = bus.port_b; changes = 0;
    for (int i = 0; i < 20; i++) begin
      bus.key_n = ((i < 3) || (i >= 5 && i < 8)) ? 4'b1110 : 4'hF;
      @(negedge CLK);
      if (bus.state_o !== 3'd1) changes++;
    end
    checks++;
    if (changes !== 0 || bus.port_b !== prevB) begin
      errors++; $display("[TB] FAIL bounce_reject changes %0d port_b %h expected 0 %h", changes, bus.port_b, prevB);
    end
    sw = 16'($urandom);
    bus.sw_data = sw; bus.sw_sext = 1'b1;
    holdKeys(4'hF, 3);
    firstChange = 0;
    for (int i = 1; i <= 14; i++) begin
      bus.key_n = (i <= 7) ? 4'b1110 : 4'hF;
      @(negedge CLK);
      if (firstChange == 0 && bus.state_o !== 3'd1) firstChange = i;
    end
    // the capture edge is D+3 after the first low sample, seen at the following negedge
    checks++;
    if (firstChange !== D + 4) begin
      errors++; $display("[TB] FAIL bounce_latency actual %0d expected %0d", firstChange, D + 4);
    end
    checks++;
    if (bus.port_b !== extend({1'b1, sw}) || bus.state_o !== 3'd2) begin
      errors++; $display("[TB] FAIL bounce_capture port_b %h state %0d expected %h 2", bus.port_b, bus.state_o, extend({1'b1, sw}));
    end
  endtask

  task automatic test_cancel;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 18; i++) begin
      bus.key_n = (i < 8) ? 4'b1101 : 4'hF;
      @(negedge CLK);
      if (bus.op_valid === 1'b1) pulses++;
    end
    checks++;
    if (dutVec !== 72'd0 || pulses !== 0) begin
      errors++; $display("[TB] FAIL cancel_clear actual %h pulses %0d expected 0 0", dutVec, pulses);
    end
  endtask

  task automatic test_cancel_enter_same;
    bus.sw_data = 16'h1234; bus.sw_sext = 1'b0;
    holdKeys(4'b1110, 8); holdKeys(4'hF, 10);
    checks++;
    if (bus.state_o !== 3'd1 || bus.port_a !== 32'h00001234) begin
      errors++; $display("[TB] FAIL both_setup state %0d port_a %h expected 1 00001234", bus.state_o, bus.port_a);
    end
    holdKeys(4'b1100, 8); holdKeys(4'hF, 10);
    checks++;
    if (dutVec !== 72'd0) begin
      errors++; $display("[TB] FAIL both_cancel_wins actual %h expected %h", dutVec, 72'd0);
    end
  endtask

  task automatic test_reset_mid;
    int firstChange;
    bus.sw_data = 16'hFFFE; bus.sw_sext = 1'b1;
    holdKeys(4'b1110, 8); holdKeys(4'hF, 10);
    holdKeys(4'b1110, 8); holdKeys(4'hF, 10);
    checks++;
    if (bus.state_o !== 3'd2) begin
      errors++; $display("[TB] FAIL rstmid_setup state actual %0d expected 2", bus.state_o);
    end
    holdKeys(4'b1110, 4);
    nRST = 1'b0;
    #1;
    checks++;
    if (dutVec !== 72'd0) begin
      errors++; $display("[TB] FAIL rstmid_clear actual %h expected %h", dutVec, 72'd0);
    end
    @(negedge CLK);
    nRST = 1'b1;
    firstChange = 0;
    for (int i = 1; i <= 16; i++) begin
      bus.key_n = (i <= 10) ? 4'b1110 : 4'hF;
      @(negedge CLK);
      if (firstChange == 0 && bus.state_o !== 3'd0) firstChange = i;
    end
    checks++;
    if (firstChange !== D + 4 || bus.state_o !== 3'd1) begin
      errors++; $display("[TB] FAIL rstmid_press at %0d state %0d expected %0d 1", firstChange, bus.state_o, D + 4);
    end
    checks++;
    if (dutVec !== modelVec) begin
      errors++; $display("[TB] FAIL rstmid_model actual %h expected %h", dutVec, modelVec);
    end
  endtask

  task automatic test_random;
    logic [3:0] keys;
    int r;
    int lowLen;
    int gap;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      keys = (r < 6) ? 4'b1110 : ((r < 9) ? 4'b1101 : 4'b1100);
      bus.sw_data = 16'($urandom);
      bus.sw_sext = 1'($urandom);
      lowLen = $urandom_range(1, 9);
      gap = $urandom_range(2, 12);
      for (int i = 0; i < lowLen + gap; i++) begin
        bus.key_n = (i < lowLen) ? keys : 4'hF;
        @(negedge CLK);
        checks++;
        if (dutVec !== modelVec) begin
          errors++; $display("[TB] FAIL random_model iter %0d actual %h expected %h", n, dutVec, modelVec);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_sequence();
    test_hold();
    test_bounce();
    test_cancel();
    test_cancel_enter_same();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
